inst_buffer_issue: RTL and testbench
====================================

Name: inst_buffer_issue

Overview:
- Per-warp two-entry instruction buffer sitting between the fetch stage and decode/issue.
- Accepts the dual instruction packets fetch produces for one warp per cycle.
- Selects one ready packet per cycle by round-robin over warps, in program order within a warp.
- Returns selectedPacketValid/selectedWarp/selectedEntry and the per-warp occupancy vector so fetch can retire its pending flags and refetch.

Parameters:
NUM_WARP, 4, number of warps.
NUM_WARP_LOG, 2, log2(NUM_WARP).
SIZE_INSTRUCTION, 64, instruction width in bits.
SIZE_PC, 32, PC width in bits; packet width is SIZE_INSTRUCTION+SIZE_PC, laid out {instruction, PC}.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
stall_i  input  1  downstream stall; freezes all state.
instWarp_i  input  NUM_WARP_LOG  warp owning the incoming packets.
instPacket0Valid_i  input  1  packet 0 valid (entry 0).
instPacket0_i  input  SIZE_INSTRUCTION+SIZE_PC  packet 0, {instruction, PC}.
instPacket1Valid_i  input  1  packet 1 valid (entry 1).
instPacket1_i  input  SIZE_INSTRUCTION+SIZE_PC  packet 1, {instruction, PC+1}.
flush_i  input  1  discard both entries of flushWarp_i (CTA exit or reconvergence).
flushWarp_i  input  NUM_WARP_LOG  warp to flush.
warpReady_i  input  NUM_WARP  per-warp issue permission from the scoreboard.
selectedPacketValid_o  output  1  registered; one packet issued.
selectedWarp_o  output  NUM_WARP_LOG  registered; warp of the issued packet.
selectedEntry_o  output  1  registered; entry index (0/1) of the issued packet.
issuePacket_o  output  SIZE_INSTRUCTION+SIZE_PC  registered; issued packet.
warpValidVector_o  output  NUM_WARP  bit w = entry0 valid OR entry1 valid of warp w (combinational from state).

Behaviour:
- State per warp: two data registers, valid0[w] and valid1[w]. Also lastWarp (round-robin pointer) and the output registers.
- Reset: all valid bits 0; lastWarp = NUM_WARP-1, so warp 0 has first priority.
- Reset values: selectedPacketValid_o=0, selectedWarp_o=0, selectedEntry_o=0, issuePacket_o=0; hence warpValidVector_o=0.
- Reset asserted mid-operation discards all buffered packets on the next edge.
- Stall: stall_i=1 means no write, no flush, no selection. Valid bits, lastWarp and all output registers hold.
- Write (stall_i=0): instPacketNValid_i stores instPacketN_i into entry N of instWarp_i and sets validN.
  - Both packets may be written in the same cycle.
  - A write to an already-valid entry overwrites its data; valid stays 1. This is a protocol violation, because fetch refetches only when both entries are empty.
- Eligibility: warp w is eligible when warpReady_i[w]=1 and (valid0[w] or valid1[w]), and warp w is not the warp being flushed this cycle.
  - Candidate entry is entry 0 if valid0[w], else entry 1.
  - Entry 1 never issues while entry 0 of the same warp is valid.
- Arbitration: the eligible warp nearest after lastWarp in increasing index order with wrap-around is chosen. lastWarp itself has lowest priority.
- Selection, same edge:
  - Clears the chosen entry's valid bit.
  - Sets lastWarp to the chosen warp.
  - Loads the output registers: selectedPacketValid_o=1, plus warp, entry and packet data.
  - Issue latency is 1 cycle from the valid bit being set.
- No eligible warp: selectedPacketValid_o=0 next cycle. The other output registers hold their last values.
- Flush (stall_i=0): clears valid0 and valid1 of flushWarp_i.
  - Flush wins over a same-cycle write to that warp; the packets are dropped.
  - Flush also wins over selection of that warp; it is excluded from arbitration.
- Same-cycle write and selection on the same warp and entry: the write wins (valid=1, new data). Selection still outputs the old data.
- Maximum throughput: one issue per cycle. Buffer capacity: 2*NUM_WARP packets.

Test Plan:
- Reset: hold reset 2 cycles -> every output reads 0. After reset, write warp 0 with warpReady_i=4'b0001 -> warp 0 issues first.
- Single warp in order: write warp 1 packets PC=0x10/0x11 with warpReady_i=4'b1111 -> next cycle selectedWarp_o=1, entry 0, PC 0x10; following cycle entry 1, PC 0x11; then selectedPacketValid_o=0 and warpValidVector_o=4'b0000.
- Round-robin: with warpReady_i=0, load warp 0 then warp 2, then set warpReady_i=4'b1111 -> issue order (0,e0),(2,e0),(0,e1),(2,e1).
- Scoreboard block: warps 0 and 3 loaded, warpReady_i=4'b1000 -> only warp 3 issues (2 packets); warpValidVector_o stays 4'b0001 until warpReady_i[0]=1.
- Flush collision: flush_i=1, flushWarp_i=2 in the same cycle as a write to warp 2 -> warpValidVector_o[2]=0 and no issue for warp 2. A subsequent flush of a loaded warp 3 clears bit 3 and blocks its issue that cycle.
- Stall: warp 1 loaded, stall_i=1 for 3 cycles with writes to warp 0 applied -> outputs, valid bits and lastWarp unchanged, warp 0 not written. After release, warp 1 issues entry 0 next cycle.

Source files
------------

// File: rtl/inst_buffer_issue_if.sv
// Fetch-to-issue bus of the per-warp instruction buffer.
//   master : fetch/stimulus side; drives packets, flush, stall and warp readiness,
//            and observes the issued packet plus per-warp occupancy.
//   slave  : instruction buffer side.
// Packets are laid out {instruction, pc}.
interface inst_buffer_issue_if #(
  parameter int unsigned NUM_WARP         = 4,
  parameter int unsigned NUM_WARP_LOG     = 2,
  parameter int unsigned SIZE_INSTRUCTION = 64,
  parameter int unsigned SIZE_PC          = 32
) ();

  localparam int unsigned PktW = SIZE_INSTRUCTION + SIZE_PC;

  logic                    stall;
  logic [NUM_WARP_LOG-1:0] inst_warp;
  logic                    inst_packet0_valid;
  logic [PktW-1:0]         inst_packet0;
  logic                    inst_packet1_valid;
  logic [PktW-1:0]         inst_packet1;
  logic                    flush;
  logic [NUM_WARP_LOG-1:0] flush_warp;
  logic [NUM_WARP-1:0]     warp_ready;
  logic                    selected_packet_valid;
  logic [NUM_WARP_LOG-1:0] selected_warp;
  logic                    selected_entry;
  logic [PktW-1:0]         issue_packet;
  logic [NUM_WARP-1:0]     warp_valid_vector;

  modport master (
    output stall, inst_warp, inst_packet0_valid, inst_packet0, inst_packet1_valid,
           inst_packet1, flush, flush_warp, warp_ready,
    input  selected_packet_valid, selected_warp, selected_entry, issue_packet,
           warp_valid_vector
  );

  modport slave (
    input  stall, inst_warp, inst_packet0_valid, inst_packet0, inst_packet1_valid,
           inst_packet1, flush, flush_warp, warp_ready,
    output selected_packet_valid, selected_warp, selected_entry, issue_packet,
           warp_valid_vector
  );

endinterface

// File: rtl/inst_buffer_issue.sv
// Per-warp two-entry instruction buffer between fetch and decode/issue.
// Fetch writes up to two packets (entry 0 / entry 1) for one warp per cycle; each cycle
// one ready warp is chosen round-robin and its oldest valid entry is issued through
// registered outputs.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of inst_buffer_issue_if (packets in, issued packet out,
//                per-warp occupancy vector out)
// NUM_WARP must equal 2**NUM_WARP_LOG.
module inst_buffer_issue #(
  parameter int unsigned NUM_WARP         = 4,
  parameter int unsigned NUM_WARP_LOG     = 2,
  parameter int unsigned SIZE_INSTRUCTION = 64,
  parameter int unsigned SIZE_PC          = 32
) (
  input logic                 clk,
  input logic                 reset,
  inst_buffer_issue_if.slave  bus
);

  localparam int unsigned PktW = SIZE_INSTRUCTION + SIZE_PC;

  logic [NUM_WARP-1:0]     valid0_q, valid0_d;
  logic [NUM_WARP-1:0]     valid1_q, valid1_d;
  logic [PktW-1:0]         data0_q [NUM_WARP];
  logic [PktW-1:0]         data1_q [NUM_WARP];
  logic [NUM_WARP_LOG-1:0] last_warp_q;

  logic                    sel_valid_q;
  logic [NUM_WARP_LOG-1:0] sel_warp_q;
  logic                    sel_entry_q;
  logic [PktW-1:0]         sel_packet_q;

  logic [NUM_WARP-1:0]     eligible;
  logic                    found;
  logic [NUM_WARP_LOG-1:0] pick_warp;
  logic [NUM_WARP_LOG-1:0] cand;
  logic                    pick_entry;
  logic [PktW-1:0]         pick_packet;

  // A warp being flushed this cycle is removed from arbitration.
  always_comb begin
    eligible = '0;
    for (int w = 0; w < NUM_WARP; w++) begin
      eligible[w] = bus.warp_ready[w] & (valid0_q[w] | valid1_q[w]) &
                    ~(bus.flush && (bus.flush_warp == NUM_WARP_LOG'(w)));
    end
  end

  // Round-robin search starting just after last_warp_q; last_warp_q itself comes last
  // because the offset NUM_WARP wraps back to it.
  always_comb begin
    found     = 1'b0;
    pick_warp = last_warp_q;
    cand      = '0;
    for (int i = 1; i <= NUM_WARP; i++) begin
      cand = last_warp_q + NUM_WARP_LOG'(i);
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        pick_warp = cand;
      end
    end
  end

  // Program order within a warp: entry 1 waits until entry 0 is gone.
  always_comb begin
    pick_entry  = ~valid0_q[pick_warp];
    pick_packet = valid0_q[pick_warp] ? data0_q[pick_warp] : data1_q[pick_warp];
  end

  // Priority (lowest to highest): selection clear, write set, flush clear.
  always_comb begin
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    if (found) begin
      if (pick_entry) valid1_d[pick_warp] = 1'b0;
      else            valid0_d[pick_warp] = 1'b0;
    end
    if (bus.inst_packet0_valid) valid0_d[bus.inst_warp] = 1'b1;
    if (bus.inst_packet1_valid) valid1_d[bus.inst_warp] = 1'b1;
    if (bus.flush) begin
      valid0_d[bus.flush_warp] = 1'b0;
      valid1_d[bus.flush_warp] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid0_q     <= '0;
      valid1_q     <= '0;
      last_warp_q  <= NUM_WARP_LOG'(NUM_WARP - 1);
      sel_valid_q  <= 1'b0;
      sel_warp_q   <= '0;
      sel_entry_q  <= 1'b0;
      sel_packet_q <= '0;
    end else if (!bus.stall) begin
      valid0_q    <= valid0_d;
      valid1_q    <= valid1_d;
      sel_valid_q <= found;
      if (found) begin
        last_warp_q  <= pick_warp;
        sel_warp_q   <= pick_warp;
        sel_entry_q  <= pick_entry;
        sel_packet_q <= pick_packet;
      end
    end
  end

  // Payload storage needs no reset; it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (!bus.stall) begin
      if (bus.inst_packet0_valid) data0_q[bus.inst_warp] <= bus.inst_packet0;
      if (bus.inst_packet1_valid) data1_q[bus.inst_warp] <= bus.inst_packet1;
    end
  end

  assign bus.selected_packet_valid = sel_valid_q;
  assign bus.selected_warp         = sel_warp_q;
  assign bus.selected_entry        = sel_entry_q;
  assign bus.issue_packet          = sel_packet_q;
  assign bus.warp_valid_vector     = valid0_q | valid1_q;

endmodule

// File: tb/tb_inst_buffer_issue.sv
module tb_inst_buffer_issue;

  localparam int unsigned NW  = 4;
  localparam int unsigned NWL = 2;
  localparam int unsigned PW  = 96;

  typedef struct {
    logic [NWL-1:0] warp;
    logic           entry;
    logic [PW-1:0]  pkt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb [$];

  inst_buffer_issue_if #(
    .NUM_WARP(NW), .NUM_WARP_LOG(NWL), .SIZE_INSTRUCTION(64), .SIZE_PC(32)
  ) bus ();

  inst_buffer_issue #(
    .NUM_WARP(NW), .NUM_WARP_LOG(NWL), .SIZE_INSTRUCTION(64), .SIZE_PC(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(input logic [31:0] pc);
    return {32'hC0DEF00D, pc, pc};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int w, input bit e, input logic [31:0] pc);
    exp_t x;
    x.warp  = NWL'(w);
    x.entry = e;
    x.pkt   = mk(pc);
    sb.push_back(x);
  endtask

  task automatic wr(input int w, input logic [31:0] pc);
    bus.inst_warp          = NWL'(w);
    bus.inst_packet0_valid = 1'b1;
    bus.inst_packet0       = mk(pc);
    bus.inst_packet1_valid = 1'b1;
    bus.inst_packet1       = mk(pc + 32'd1);
  endtask

  task automatic idle();
    bus.inst_packet0_valid = 1'b0;
    bus.inst_packet1_valid = 1'b0;
    bus.flush              = 1'b0;
  endtask

  // One clock; outputs sampled 1 time unit after the edge, issues checked against the
  // scoreboard.
  task automatic tick(input bit exp_valid);
    exp_t x;
    @(posedge clk);
    #1;
    chk("sel_valid", 128'(bus.selected_packet_valid), 128'(exp_valid));
    if (bus.selected_packet_valid === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow observed=issue expected=none");
      end
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("sel_warp", 128'(bus.selected_warp), 128'(x.warp));
        chk("sel_entry", 128'(bus.selected_entry), 128'(x.entry));
        chk("issue_packet", 128'(bus.issue_packet), 128'(x.pkt));
      end
    end
    idle();
  endtask

  task automatic vvec(input string tag, input logic [NW-1:0] exp);
    chk(tag, 128'(bus.warp_valid_vector), 128'(exp));
  endtask

  initial begin
    bus.stall        = 1'b0;
    bus.inst_warp    = '0;
    bus.inst_packet0 = '0;
    bus.inst_packet1 = '0;
    bus.flush_warp   = '0;
    bus.warp_ready   = '0;
    idle();

    // Reset
    reset = 1'b1;
    tick(1'b0);
    tick(1'b0);
    chk("rst_warp", 128'(bus.selected_warp), 128'(0));
    chk("rst_entry", 128'(bus.selected_entry), 128'(0));
    chk("rst_packet", 128'(bus.issue_packet), 128'(0));
    vvec("rst_vvec", 4'b0000);
    reset = 1'b0;

    // Round-robin; warp 0 has first priority out of reset
    bus.warp_ready = 4'b0000;
    wr(0, 32'h20);
    tick(1'b0);
    vvec("rr_vvec0", 4'b0001);
    wr(2, 32'h30);
    tick(1'b0);
    vvec("rr_vvec1", 4'b0101);
    bus.warp_ready = 4'b1111;
    push(0, 0, 32'h20);
    push(2, 0, 32'h30);
    push(0, 1, 32'h21);
    push(2, 1, 32'h31);
    repeat (4) tick(1'b1);
    tick(1'b0);
    vvec("rr_vvec2", 4'b0000);

    // Single warp, program order
    wr(1, 32'h10);
    tick(1'b0);
    push(1, 0, 32'h10);
    push(1, 1, 32'h11);
    tick(1'b1);
    vvec("sw_vvec0", 4'b0010);
    tick(1'b1);
    tick(1'b0);
    vvec("sw_vvec1", 4'b0000);

    // Scoreboard readiness blocks warp 0
    bus.warp_ready = 4'b0000;
    wr(0, 32'h40);
    tick(1'b0);
    wr(3, 32'h50);
    tick(1'b0);
    bus.warp_ready = 4'b1000;
    push(3, 0, 32'h50);
    push(3, 1, 32'h51);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    vvec("blk_vvec0", 4'b0001);
    tick(1'b0);
    vvec("blk_vvec1", 4'b0001);
    bus.warp_ready = 4'b0001;
    push(0, 0, 32'h40);
    push(0, 1, 32'h41);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    vvec("blk_vvec2", 4'b0000);

    // Flush beats a same-cycle write, then flush beats selection
    bus.warp_ready = 4'b1111;
    wr(2, 32'h60);
    bus.flush      = 1'b1;
    bus.flush_warp = 2'd2;
    tick(1'b0);
    vvec("fl_vvec0", 4'b0000);
    tick(1'b0);
    bus.warp_ready = 4'b0000;
    wr(3, 32'h70);
    tick(1'b0);
    vvec("fl_vvec1", 4'b1000);
    bus.warp_ready = 4'b1111;
    bus.flush      = 1'b1;
    bus.flush_warp = 2'd3;
    tick(1'b0);
    vvec("fl_vvec2", 4'b0000);
    tick(1'b0);

    // Stall freezes everything, including the ignored write to warp 0
    bus.warp_ready = 4'b0000;
    wr(1, 32'h80);
    tick(1'b0);
    vvec("st_vvec0", 4'b0010);
    bus.warp_ready = 4'b1111;
    bus.stall      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr(0, 32'h90);
      tick(1'b0);
      vvec("st_vvec", 4'b0010);
      chk("st_warp", 128'(bus.selected_warp), 128'(0));
      chk("st_entry", 128'(bus.selected_entry), 128'(1));
      chk("st_packet", 128'(bus.issue_packet), 128'(mk(32'h41)));
    end
    bus.stall = 1'b0;
    push(1, 0, 32'h80);
    push(1, 1, 32'h81);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    vvec("st_vvec1", 4'b0000);

    // Reset mid-operation drops buffered packets
    bus.warp_ready = 4'b0000;
    wr(2, 32'hA0);
    tick(1'b0);
    vvec("mr_vvec0", 4'b0100);
    reset = 1'b1;
    tick(1'b0);
    vvec("mr_vvec1", 4'b0000);
    reset = 1'b0;
    bus.warp_ready = 4'b1111;
    tick(1'b0);
    vvec("mr_vvec2", 4'b0000);

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
